// File: rtl/uart_rx_if.sv
// Receive-side bus of uart_rx: FIFO head, pop/clear strobes, sticky error flags, FSM state.
// Handshake: while valid=1, dout holds the oldest unread byte; re=1 on a clock edge with valid=1 pops it, re with valid=0 is ignored.
interface uart_rx_if;
    logic [7:0] dout;
    logic       valid;
    logic       re;
    logic       clr;
    logic       frame_err;
    logic       overrun;
    logic [2:0] state_dbg;

    modport master (
        output dout, valid, frame_err, overrun, state_dbg,
        input  re, clr
    );

    modport slave (
        input  dout, valid, frame_err, overrun, state_dbg,
        output re, clr
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, and a small receive FIFO
// with sticky frame-error and overrun flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      idx, idx_n;
    logic [7:0]      shreg, shreg_n;
    logic            sync1, rx_s;
    logic            push, ferr_set;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            pop, full, do_write, ovr_set;
    logic            frame_err_q, overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        shreg_n  = shreg;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                // Re-check the start bit at its midpoint to reject glitches.
                if (cnt == HALF_CNT) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == LAST_CNT) begin
                    cnt_n          = '0;
                    shreg_n[idx]   = rx_s;
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 3'd1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == LAST_CNT) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_n  = WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
    assign pop      = bus.re && (count != '0);
    assign full     = (count == FULL_CNT);
    assign do_write = push && (!full || pop);
    assign ovr_set  = push && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(do_write) - (AW + 1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (ferr_set)     frame_err_q <= 1'b1;
            else if (bus.clr) frame_err_q <= 1'b0;
            if (ovr_set)      overrun_q   <= 1'b1;
            else if (bus.clr) overrun_q   <= 1'b0;
        end
    end

    assign bus.dout      = mem[rd_ptr];
    assign bus.valid     = (count != '0);
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.state_dbg = state;
endmodule
